// File: rtl/face_tx_pkg.sv
// Shared definitions for the face-result return path: packet headers, the
// buffered record layout, packet lengths and the packetizer state encoding.
// Packet lengths grow by one checksum byte when FACE_TX_CHECKSUM_EN is defined.
package face_tx_pkg;

    localparam logic [7:0] FACE_HDR = 8'hA5;
    localparam logic [7:0] DONE_HDR = 8'h5A;

    typedef struct packed {
        logic [3:0]  pyr;
        logic [15:0] row;
        logic [15:0] col;
    } face_rec_t;

`ifdef FACE_TX_CHECKSUM_EN
    localparam int FACE_PKT_LEN = 7;
    localparam int DONE_PKT_LEN = 4;
`else
    localparam int FACE_PKT_LEN = 6;
    localparam int DONE_PKT_LEN = 3;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND_FACE,
        ST_SEND_DONE
    } pkt_state_t;

    // Coordinates wider than 16 bits clamp to all ones instead of wrapping.
    function automatic logic [15:0] sat16(input logic [31:0] value);
        return (|value[31:16]) ? 16'hFFFF : value[15:0];
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer: start bit 0, eight data bits LSB first, stop bit 1,
// each held CLKS_PER_BIT cycles. A new byte can be taken in the last cycle of
// the stop bit so back-to-back frames leave no idle gap on the line.
module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       tx,
    output logic       active
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] clk_cnt;
    logic [3:0]    bit_idx;
    logic [7:0]    shreg;

    assign byte_ready = !active || ((bit_idx == 4'd9) && (clk_cnt == LAST_CLK));

    // Bit timing and shifting; bit_idx 0 is the start bit, 1..8 data, 9 stop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active  <= 1'b0;
            tx      <= 1'b1;
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else if (byte_valid && byte_ready) begin
            active  <= 1'b1;
            tx      <= 1'b0;
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= byte_data;
        end else if (active) begin
            if (clk_cnt == LAST_CLK) begin
                clk_cnt <= '0;
                if (bit_idx == 4'd9) begin
                    active <= 1'b0;
                    tx     <= 1'b1;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    if (bit_idx == 4'd8) begin
                        tx <= 1'b1;
                    end else begin
                        tx    <= shreg[0];
                        shreg <= {1'b0, shreg[7:1]};
                    end
                end
            end else begin
                clk_cnt <= clk_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/face_result_tx.sv
// Face-result transmitter: buffers detections from the Viola-Jones pipeline in
// a small FIFO, tracks per-run face counts, and sends framed face/done packets
// over an 8N1 UART. Optional macro FACE_TX_CHECKSUM_EN appends an XOR byte.
module face_result_tx
    import face_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0][31:0] face_coords,
    input  logic             face_coords_ready,
    input  logic [3:0]       pyramid_number,
    input  logic             vj_pipeline_done,
    output logic             tx,
    output logic             busy,
    output logic             overflow,
    output logic [15:0]      dropped_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    face_rec_t   fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full;
    logic        push, pop, drop, take_done;
    face_rec_t   in_rec, cur_rec;
    logic [15:0] face_cnt, cnt_inc, done_snap, cur_cnt;
    logic        done_pending;
    pkt_state_t  state, state_next;
    logic [2:0]  idx;
    logic        byte_valid, byte_ready, tx_active;
    logic [7:0]  byte_data, face_csum, done_csum;

    assign in_rec     = {pyramid_number, sat16(face_coords[0]), sat16(face_coords[1])};
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push       = face_coords_ready && (!fifo_full || pop);
    assign drop       = face_coords_ready && fifo_full && !pop;
    assign cnt_inc    = (face_cnt == 16'hFFFF) ? face_cnt : face_cnt + 16'd1;
    assign busy       = !fifo_empty || done_pending || (state != ST_IDLE) || tx_active;

    // Record storage; contents need no reset since the pointers gate validity.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= in_rec;
    end

    // FIFO pointers carry an extra wrap bit to tell full from empty.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Run bookkeeping: face counter, pending done snapshot and loss reporting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            face_cnt      <= '0;
            done_snap     <= '0;
            done_pending  <= 1'b0;
            overflow      <= 1'b0;
            dropped_count <= '0;
        end else begin
            if (vj_pipeline_done) begin
                face_cnt     <= '0;
                done_snap    <= face_coords_ready ? cnt_inc : face_cnt;
                done_pending <= 1'b1;
            end else begin
                if (face_coords_ready) face_cnt <= cnt_inc;
                if (take_done) done_pending <= 1'b0;
            end
            if (drop || (vj_pipeline_done && done_pending && !take_done)) overflow <= 1'b1;
            if (drop && (dropped_count != 16'hFFFF)) dropped_count <= dropped_count + 16'd1;
        end
    end

    // Packetizer state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Packetizer next state; queued faces always go out ahead of a done packet.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        take_done  = 1'b0;
        byte_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_SEND_FACE;
                end else if (done_pending) begin
                    take_done  = 1'b1;
                    state_next = ST_SEND_DONE;
                end
            end
            ST_SEND_FACE: begin
                byte_valid = 1'b1;
                if (byte_ready && (idx == 3'(FACE_PKT_LEN - 1))) state_next = ST_IDLE;
            end
            ST_SEND_DONE: begin
                byte_valid = 1'b1;
                if (byte_ready && (idx == 3'(DONE_PKT_LEN - 1))) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Packet payload registers and byte index within the current packet.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx     <= '0;
            cur_rec <= '0;
            cur_cnt <= '0;
        end else if (pop) begin
            cur_rec <= fifo_mem[rd_ptr[AW-1:0]];
            idx     <= '0;
        end else if (take_done) begin
            cur_cnt <= done_snap;
            idx     <= '0;
        end else if (byte_valid && byte_ready) begin
            idx <= idx + 3'd1;
        end
    end

    assign face_csum = FACE_HDR ^ {4'h0, cur_rec.pyr} ^ cur_rec.row[15:8] ^ cur_rec.row[7:0]
                     ^ cur_rec.col[15:8] ^ cur_rec.col[7:0];
    assign done_csum = DONE_HDR ^ cur_cnt[15:8] ^ cur_cnt[7:0];

    // Byte selection; the trailing checksum slot is only reached when enabled.
    always_comb begin
        byte_data = 8'h00;
        if (state == ST_SEND_FACE) begin
            case (idx)
                3'd0:    byte_data = FACE_HDR;
                3'd1:    byte_data = {4'h0, cur_rec.pyr};
                3'd2:    byte_data = cur_rec.row[15:8];
                3'd3:    byte_data = cur_rec.row[7:0];
                3'd4:    byte_data = cur_rec.col[15:8];
                3'd5:    byte_data = cur_rec.col[7:0];
                default: byte_data = face_csum;
            endcase
        end else begin
            case (idx)
                3'd0:    byte_data = DONE_HDR;
                3'd1:    byte_data = cur_cnt[15:8];
                3'd2:    byte_data = cur_cnt[7:0];
                default: byte_data = done_csum;
            endcase
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clock      (clock),
        .reset      (reset),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .tx         (tx),
        .active     (tx_active)
    );

endmodule

// File: tb/tb_face_result_tx.sv
// Self-checking bench for face_result_tx: decodes the UART line into bytes and
// compares them with packets built from the packet rules by a reference model.
module tb_face_result_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef FACE_TX_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [1:0][31:0] face_coords = '0;
    logic             face_coords_ready = 1'b0;
    logic [3:0]       pyramid_number = 4'h0;
    logic             vj_pipeline_done = 1'b0;
    logic             tx, busy, overflow;
    logic [15:0]      dropped_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int model_cnt = 0;
    int frame_errs = 0;

    logic [7:0] exp_q[$];
    bit         exp_first[$];
    logic [7:0] rx_q[$];
    int         rx_t[$];

    bit         rx_busy = 1'b0;
    int         rx_cnt = 0;
    int         rx_k = 0;
    int         rx_start = 0;
    logic [9:0] rx_bits = '0;

    face_result_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .face_coords       (face_coords),
        .face_coords_ready (face_coords_ready),
        .pyramid_number    (pyramid_number),
        .vj_pipeline_done  (vj_pipeline_done),
        .tx                (tx),
        .busy              (busy),
        .overflow          (overflow),
        .dropped_count     (dropped_count)
    );

    always #5 clock = ~clock;

    // Free-running cycle count used to time-stamp received frames.
    always @(posedge clock) cyc <= cyc + 1;

    // UART line decoder sampling mid-bit on the falling clock edge.
    always @(negedge clock) begin
        if (reset) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (tx === 1'b0) begin
                rx_busy  = 1'b1;
                rx_cnt   = 0;
                rx_start = cyc;
            end
        end else begin
            rx_cnt = rx_cnt + 1;
            if ((rx_cnt % CPB) == (CPB / 2)) begin
                rx_k = rx_cnt / CPB;
                rx_bits[rx_k] = tx;
                if (rx_k == 9) begin
                    if (rx_bits[0] !== 1'b0 || rx_bits[9] !== 1'b1) frame_errs = frame_errs + 1;
                    rx_q.push_back(rx_bits[8:1]);
                    rx_t.push_back(rx_start);
                    rx_busy = 1'b0;
                end
            end
        end
    end

    // Runaway guard so the run always terminates.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic emit_packet(input logic [7:0] pkt [6], input int n);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(pkt[i]);
            exp_first.push_back(i == 0);
            x = x ^ pkt[i];
        end
        if (CSUM) begin
            exp_q.push_back(x);
            exp_first.push_back(1'b0);
        end
    endtask

    task automatic model_face(input logic [3:0] pyr, input logic [31:0] row, input logic [31:0] col);
        logic [15:0] r, c;
        logic [7:0]  pkt [6];
        r = (row > 32'h0000_FFFF) ? 16'hFFFF : row[15:0];
        c = (col > 32'h0000_FFFF) ? 16'hFFFF : col[15:0];
        pkt = '{8'hA5, {4'h0, pyr}, r[15:8], r[7:0], c[15:8], c[7:0]};
        emit_packet(pkt, 6);
    endtask

    task automatic model_done(input logic [15:0] cnt);
        logic [7:0] pkt [6];
        pkt = '{8'h5A, cnt[15:8], cnt[7:0], 8'h00, 8'h00, 8'h00};
        emit_packet(pkt, 3);
    endtask

    // Drives one cycle of pulses; called at a falling edge, returns at the next.
    task automatic apply_stimulus(input bit face, input logic [3:0] pyr, input logic [31:0] row,
                                  input logic [31:0] col, input bit done);
        face_coords_ready = face;
        pyramid_number    = pyr;
        face_coords[0]    = row;
        face_coords[1]    = col;
        vj_pipeline_done  = done;
        @(negedge clock);
        face_coords_ready = 1'b0;
        vj_pipeline_done  = 1'b0;
    endtask

    task automatic drive_face(input logic [3:0] pyr, input logic [31:0] row, input logic [31:0] col,
                              input bit with_done, input bit kept);
        apply_stimulus(1'b1, pyr, row, col, with_done);
        model_cnt++;
        if (kept) model_face(pyr, row, col);
        if (with_done) begin
            model_done(16'(model_cnt));
            model_cnt = 0;
        end
    endtask

    task automatic drive_done();
        apply_stimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        model_done(16'(model_cnt));
        model_cnt = 0;
    endtask

    task automatic drain_and_compare(input string tag);
        int waited;
        waited = 0;
        while ((busy !== 1'b0 || rx_busy) && waited < 5000) begin
            @(negedge clock);
            waited++;
        end
        check_output({tag, "_drain"}, 32'(waited < 5000), 32'd1);
        check_output({tag, "_frame"}, 32'(frame_errs), 32'd0);
        check_output({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            check_output($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
            if (i > 0 && !exp_first[i])
                check_output($sformatf("%s_gap%0d", tag, i), 32'(rx_t[i] - rx_t[i-1]), 32'(10 * CPB));
        end
    endtask

    task automatic flush_queues();
        exp_q.delete();
        exp_first.delete();
        rx_q.delete();
        rx_t.delete();
        frame_errs = 0;
    endtask

    function automatic logic [31:0] rand_coord();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 3) != 0) v = v & 32'h0000_FFFF;
        return v;
    endfunction

    initial begin
        logic [7:0]  lit [6];
        int          n, sel, waited;
        logic [3:0]  p;
        logic [31:0] r, c;

        // Reset state
        repeat (3) @(negedge clock);
        check_output("rst_tx", 32'(tx), 32'd1);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_ovf", 32'(overflow), 32'd0);
        check_output("rst_drop", 32'(dropped_count), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check_output("idle_tx", 32'(tx), 32'd1);
        check_output("idle_busy", 32'(busy), 32'd0);

        // Single face: latency and literal bytes
        drive_face(4'd2, 32'h12, 32'h34, 1'b0, 1'b1);
        check_output("lat_e0_tx", 32'(tx), 32'd1);
        check_output("lat_e0_busy", 32'(busy), 32'd1);
        @(negedge clock);
        check_output("lat_e1_tx", 32'(tx), 32'd1);
        @(negedge clock);
        check_output("lat_e2_tx", 32'(tx), 32'd0);
        drain_and_compare("single");
        lit = '{8'hA5, 8'h02, 8'h00, 8'h12, 8'h00, 8'h34};
        for (int i = 0; i < 6 && i < rx_q.size(); i++)
            check_output($sformatf("single_lit%0d", i), 32'(rx_q[i]), 32'(lit[i]));
        flush_queues();

        // Close the run of the single face
        drive_done();
        drain_and_compare("done1");
        flush_queues();

        // Three spaced faces then done
        for (int i = 0; i < 3; i++) begin
            drive_face(4'(i + 1), 32'(16 * i + 5), 32'(300 + i), 1'b0, 1'b1);
            repeat (7) @(negedge clock);
        end
        drive_done();
        drain_and_compare("three");
        flush_queues();

        // Two faces, then a face and done in the same cycle
        drive_face(4'd3, 32'h0100, 32'h0200, 1'b0, 1'b1);
        drive_face(4'd4, 32'h0101, 32'h0201, 1'b0, 1'b1);
        drive_face(4'd5, 32'h0102, 32'h0202, 1'b1, 1'b1);
        drain_and_compare("same_cycle");
        flush_queues();

        // Saturation of a wide row coordinate
        drive_face(4'h9, 32'h0001_0000, 32'd7, 1'b0, 1'b1);
        drive_done();
        drain_and_compare("sat");
        if (rx_q.size() >= 6) begin
            check_output("sat_row_hi", 32'(rx_q[2]), 32'hFF);
            check_output("sat_row_lo", 32'(rx_q[3]), 32'hFF);
            check_output("sat_col_hi", 32'(rx_q[4]), 32'h00);
            check_output("sat_col_lo", 32'(rx_q[5]), 32'h07);
        end
        flush_queues();
        check_output("pre_ovf", 32'(overflow), 32'd0);

        // Overflow: twenty back-to-back faces; one pop happens during the burst
        for (int i = 0; i < 20; i++)
            drive_face(4'($urandom), rand_coord(), rand_coord(), 1'b0, i < DEPTH + 1);
        check_output("ovf_flag", 32'(overflow), 32'd1);
        check_output("ovf_dropped", 32'(dropped_count), 32'd15);
        drive_done();
        drain_and_compare("ovf");
        flush_queues();

        // Randomized rounds of faces with a done closing some of them
        for (int round = 0; round < 8; round++) begin
            n   = $urandom_range(1, 4);
            sel = $urandom_range(0, 2);
            for (int j = 0; j < n; j++) begin
                p = 4'($urandom);
                r = rand_coord();
                c = rand_coord();
                drive_face(p, r, c, (sel == 1) && (j == n - 1), 1'b1);
                if (round[0]) repeat ($urandom_range(1, 30)) @(negedge clock);
            end
            if (sel == 0) drive_done();
            drain_and_compare($sformatf("rnd%0d", round));
            flush_queues();
        end

        // Reset in the third data bit of a done header (5A, bit 2 is low)
        drive_done();
        waited = 0;
        while (tx !== 1'b0 && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        check_output("rst_mid_start", 32'(waited < 100), 32'd1);
        repeat (13) @(negedge clock);
        check_output("rst_mid_pre_tx", 32'(tx), 32'd0);
        #1 reset = 1'b1;
        #1;
        check_output("rst_mid_tx", 32'(tx), 32'd1);
        check_output("rst_mid_busy", 32'(busy), 32'd0);
        check_output("rst_mid_ovf", 32'(overflow), 32'd0);
        check_output("rst_mid_drop", 32'(dropped_count), 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        flush_queues();
        model_cnt = 0;
        @(negedge clock);
        drive_face(4'($urandom), rand_coord(), rand_coord(), 1'b0, 1'b1);
        drive_done();
        drain_and_compare("post_rst");
        flush_queues();
        check_output("end_ovf", 32'(overflow), 32'd0);
        check_output("end_drop", 32'(dropped_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
